// File: rtl/holo_pkg.sv
// Shared definitions for the HoloRiscV front-end: RV32I major opcodes, the fetch
// state encoding and the instruction length.
package holo_pkg;

   localparam int RV_ILEN = 32;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_ALU    = 7'b0110011;

   typedef enum logic [1:0] {
      FETCH_IDLE  = 2'd0,
      FETCH_REQ   = 2'd1,
      FETCH_DRAIN = 2'd2
   } fetchState_t;

endpackage

// File: rtl/holo_fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instruction} entries; flush empties it in one
// cycle and wins over a same-cycle push or pop.
module holo_fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_flush,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_pushData,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_headData,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] bumpPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wrPtr] <= i_pushData;
            r_wrPtr        <= bumpPtr(r_wrPtr);
         end
         if (i_pop) r_rdPtr <= bumpPtr(r_rdPtr);
         if (i_push && !i_pop)      r_count <= r_count + CNT_W'(1);
         else if (!i_push && i_pop) r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_headData = r_mem[r_rdPtr];
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;

endmodule

// File: rtl/holo_fetch_unit.sv
// Instruction fetch front-end: assembles 32-bit little-endian instructions from BUS_W-wide
// memory beats, prefetches them into a FIFO and accepts PC redirects from execute.
module holo_fetch_unit
   import holo_pkg::*;
#(
   parameter int                BUS_W    = 8,
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [BUS_W-1:0]   mem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [RV_ILEN-1:0] instr_data,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               busy
);

   localparam int NBEATS     = RV_ILEN / BUS_W;
   localparam int BEAT_BYTES = BUS_W / 8;
   localparam int BEAT_W     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int CNT_W      = $clog2(DEPTH+1);
   localparam int FIFO_W     = RV_ILEN + ADDR_W;
   localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(3);

   generate
      if (BUS_W != 8 && BUS_W != 16 && BUS_W != 32) begin : g_badBusW
         $error("holo_fetch_unit: BUS_W must be 8, 16 or 32");
      end
      if (DEPTH < 1) begin : g_badDepth
         $error("holo_fetch_unit: DEPTH must be at least 1");
      end
   endgenerate

   fetchState_t          r_state;
   logic [ADDR_W-1:0]    r_fetchPc;
   logic [ADDR_W-1:0]    r_memAddr;
   logic                 r_memReq;
   logic [BEAT_W-1:0]    r_beat;
   logic [RV_ILEN-1:0]   r_instrBuf;

   logic                 w_lastBeat;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_empty;
   logic [CNT_W-1:0]     w_count;
   logic [CNT_W:0]       w_countNext;
   logic [ADDR_W-1:0]    w_nextPc;
   logic [RV_ILEN-1:0]   w_assembled;
   logic [FIFO_W-1:0]    w_head;

   // Redirect squashes both the final-beat push and any pop in the same cycle.
   assign w_lastBeat  = (r_beat == BEAT_W'(NBEATS-1));
   assign w_push      = (r_state == FETCH_REQ) && mem_ack && w_lastBeat && !redirect_valid;
   assign w_pop       = instr_valid && instr_ready && !redirect_valid;
   assign w_countNext = {1'b0, w_count} + {{CNT_W{1'b0}}, w_push} - {{CNT_W{1'b0}}, w_pop};
   assign w_nextPc    = r_fetchPc + ADDR_W'(4);

   always_comb begin
      w_assembled = r_instrBuf;
      w_assembled[(NBEATS-1)*BUS_W +: BUS_W] = mem_rdata;
   end

   // While in REQ the instruction being assembled already owns a FIFO slot, so IDLE only
   // starts a new instruction when the FIFO itself has room.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= FETCH_IDLE;
         r_fetchPc  <= RESET_PC & PC_MASK;
         r_memAddr  <= '0;
         r_memReq   <= 1'b0;
         r_beat     <= '0;
         r_instrBuf <= '0;
      end else if (redirect_valid) begin
         r_fetchPc <= redirect_pc & PC_MASK;
         r_beat    <= '0;
         r_memReq  <= 1'b1;
         if (r_memReq && !mem_ack) begin
            r_state <= FETCH_DRAIN;
         end else begin
            r_state   <= FETCH_REQ;
            r_memAddr <= redirect_pc & PC_MASK;
         end
      end else begin
         unique case (r_state)
            FETCH_IDLE: begin
               if (w_count < CNT_W'(DEPTH)) begin
                  r_state   <= FETCH_REQ;
                  r_memReq  <= 1'b1;
                  r_memAddr <= r_fetchPc;
               end
            end
            FETCH_REQ: begin
               if (mem_ack) begin
                  if (!w_lastBeat) begin
                     r_instrBuf[r_beat*BUS_W +: BUS_W] <= mem_rdata;
                     r_beat    <= r_beat + BEAT_W'(1);
                     r_memAddr <= r_memAddr + ADDR_W'(BEAT_BYTES);
                  end else begin
                     r_beat    <= '0;
                     r_fetchPc <= w_nextPc;
                     if (w_countNext < (CNT_W+1)'(DEPTH)) begin
                        r_memAddr <= w_nextPc;
                     end else begin
                        r_state  <= FETCH_IDLE;
                        r_memReq <= 1'b0;
                     end
                  end
               end
            end
            FETCH_DRAIN: begin
               if (mem_ack) begin
                  r_state   <= FETCH_REQ;
                  r_memAddr <= r_fetchPc;
               end
            end
            default: begin
               r_state  <= FETCH_IDLE;
               r_memReq <= 1'b0;
            end
         endcase
      end
   end

   holo_fetch_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (redirect_valid),
      .i_push     (w_push),
      .i_pushData ({r_fetchPc, w_assembled}),
      .i_pop      (w_pop),
      .o_headData (w_head),
      .o_empty    (w_empty),
      .o_count    (w_count)
   );

   assign instr_valid          = !w_empty;
   assign {instr_pc, instr_data} = w_head;
   assign mem_req              = r_memReq;
   assign busy                 = r_memReq;
   assign mem_addr             = r_memAddr;

endmodule

// File: tb/tb_holo_fetch_unit.sv
// Directed bench for holo_fetch_unit: a byte-wide and a word-wide instance share clock and
// reset, each fed by a combinational memory model with a controllable ack.
module tb_holo_fetch_unit;

   logic        clk;
   logic        rst;

   logic        req8, ack8, redir8, valid8, ready8, busy8, ackEn8;
   logic [31:0] addr8, redirPc8, data8, pc8;
   logic [7:0]  rdata8;

   logic        req32, ack32, redir32, valid32, ready32, busy32, ackEn32;
   logic [31:0] addr32, redirPc32, data32, pc32, rdata32;

   int checks;
   int errors;
   int ackCount8;

   // Byte image: 0x13,0x05,0x10,0x00 at address 0, address ^ 0x5A elsewhere.
   function automatic logic [7:0] memByte(input logic [31:0] a);
      case (a)
         32'd0:   return 8'h13;
         32'd1:   return 8'h05;
         32'd2:   return 8'h10;
         32'd3:   return 8'h00;
         default: return a[7:0] ^ 8'h5A;
      endcase
   endfunction

   function automatic logic [31:0] expInstr(input logic [31:0] a);
      return {memByte(a + 32'd3), memByte(a + 32'd2), memByte(a + 32'd1), memByte(a)};
   endfunction

   assign ack8    = req8 & ackEn8;
   assign rdata8  = memByte(addr8);
   assign ack32   = req32 & ackEn32;
   assign rdata32 = expInstr(addr32);

   holo_fetch_unit #(.BUS_W(8), .ADDR_W(32), .DEPTH(2), .RESET_PC(32'h0)) dut8 (
      .clk(clk), .rst(rst), .mem_req(req8), .mem_addr(addr8), .mem_ack(ack8),
      .mem_rdata(rdata8), .redirect_valid(redir8), .redirect_pc(redirPc8),
      .instr_valid(valid8), .instr_ready(ready8), .instr_data(data8), .instr_pc(pc8),
      .busy(busy8)
   );

   holo_fetch_unit #(.BUS_W(32), .ADDR_W(32), .DEPTH(2), .RESET_PC(32'h0)) dut32 (
      .clk(clk), .rst(rst), .mem_req(req32), .mem_addr(addr32), .mem_ack(ack32),
      .mem_rdata(rdata32), .redirect_valid(redir32), .redirect_pc(redirPc32),
      .instr_valid(valid32), .instr_ready(ready32), .instr_data(data32), .instr_pc(pc32),
      .busy(busy32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) ackCount8 <= 0;
      else if (req8 && ack8) ackCount8 <= ackCount8 + 1;
   end

   task automatic doReset();
      rst = 1'b1;
      redir8 = 1'b0;
      redir32 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (req8 !== 1'b0)    begin errors++; $display("[TB] FAIL reset_req8: got %b want 0", req8); end
      checks++; if (busy8 !== 1'b0)   begin errors++; $display("[TB] FAIL reset_busy8: got %b want 0", busy8); end
      checks++; if (valid8 !== 1'b0)  begin errors++; $display("[TB] FAIL reset_valid8: got %b want 0", valid8); end
      checks++; if (data8 !== 32'h0)  begin errors++; $display("[TB] FAIL reset_data8: got %h want 0", data8); end
      checks++; if (pc8 !== 32'h0)    begin errors++; $display("[TB] FAIL reset_pc8: got %h want 0", pc8); end
      checks++; if (req32 !== 1'b0)   begin errors++; $display("[TB] FAIL reset_req32: got %b want 0", req32); end
      checks++; if (valid32 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid32: got %b want 0", valid32); end
      checks++; if (data32 !== 32'h0) begin errors++; $display("[TB] FAIL reset_data32: got %h want 0", data32); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (req8 !== 1'b1)    begin errors++; $display("[TB] FAIL first_req8: got %b want 1", req8); end
      checks++; if (addr8 !== 32'h0)  begin errors++; $display("[TB] FAIL first_addr8: got %h want 0", addr8); end
      checks++; if (req32 !== 1'b1)   begin errors++; $display("[TB] FAIL first_req32: got %b want 1", req32); end
   endtask

   task automatic test_bus8_fetch();
      int n;
      ackEn8 = 1'b1;
      ready8 = 1'b0;
      doReset();
      n = 0;
      while (valid8 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      checks++; if (valid8 !== 1'b1)      begin errors++; $display("[TB] FAIL bus8_valid_timeout: got %b want 1", valid8); end
      checks++; if (ackCount8 !== 4)      begin errors++; $display("[TB] FAIL bus8_latency_acks: got %0d want 4", ackCount8); end
      checks++; if (data8 !== 32'h00100513) begin errors++; $display("[TB] FAIL bus8_data: got %h want 00100513", data8); end
      checks++; if (pc8 !== 32'h0)        begin errors++; $display("[TB] FAIL bus8_pc: got %h want 0", pc8); end
   endtask

   task automatic test_full();
      int n;
      repeat (20) @(negedge clk);
      checks++; if (ackCount8 !== 8) begin errors++; $display("[TB] FAIL full_acks: got %0d want 8", ackCount8); end
      checks++; if (req8 !== 1'b0)   begin errors++; $display("[TB] FAIL full_req: got %b want 0", req8); end
      checks++; if (busy8 !== 1'b0)  begin errors++; $display("[TB] FAIL full_busy: got %b want 0", busy8); end
      checks++; if (pc8 !== 32'h0)   begin errors++; $display("[TB] FAIL full_head_pc: got %h want 0", pc8); end
      ready8 = 1'b1;
      @(negedge clk);
      ready8 = 1'b0;
      checks++; if (valid8 !== 1'b1)         begin errors++; $display("[TB] FAIL pop_valid: got %b want 1", valid8); end
      checks++; if (pc8 !== 32'h4)           begin errors++; $display("[TB] FAIL pop_pc: got %h want 4", pc8); end
      checks++; if (data8 !== 32'h5D5C5F5E)  begin errors++; $display("[TB] FAIL pop_data: got %h want 5d5c5f5e", data8); end
      n = 0;
      while (req8 !== 1'b1 && n < 5) begin @(negedge clk); n++; end
      checks++; if (req8 !== 1'b1)   begin errors++; $display("[TB] FAIL resume_req: got %b want 1", req8); end
      checks++; if (addr8 !== 32'h8) begin errors++; $display("[TB] FAIL resume_addr: got %h want 8", addr8); end
      repeat (20) @(negedge clk);
      checks++; if (ackCount8 !== 12) begin errors++; $display("[TB] FAIL refill_acks: got %0d want 12", ackCount8); end
      checks++; if (req8 !== 1'b0)    begin errors++; $display("[TB] FAIL refill_req: got %b want 0", req8); end
   endtask

   task automatic test_redirect();
      int n;
      ackEn8 = 1'b1;
      ready8 = 1'b0;
      doReset();
      n = 0;
      while (!(req8 === 1'b1 && addr8 === 32'h2) && n < 10) begin @(negedge clk); n++; end
      checks++; if (addr8 !== 32'h2) begin errors++; $display("[TB] FAIL redir_beat2_timeout: got %h want 2", addr8); end
      ackEn8 = 1'b0;
      redir8 = 1'b1;
      redirPc8 = 32'h43;
      @(negedge clk);
      redir8 = 1'b0;
      checks++; if (req8 !== 1'b1)   begin errors++; $display("[TB] FAIL drain_req: got %b want 1", req8); end
      checks++; if (addr8 !== 32'h2) begin errors++; $display("[TB] FAIL drain_addr: got %h want 2", addr8); end
      repeat (2) @(negedge clk);
      checks++; if (req8 !== 1'b1)   begin errors++; $display("[TB] FAIL drain_hold_req: got %b want 1", req8); end
      checks++; if (addr8 !== 32'h2) begin errors++; $display("[TB] FAIL drain_hold_addr: got %h want 2", addr8); end
      checks++; if (valid8 !== 1'b0) begin errors++; $display("[TB] FAIL drain_valid: got %b want 0", valid8); end
      ackEn8 = 1'b1;
      @(negedge clk);
      checks++; if (req8 !== 1'b1)    begin errors++; $display("[TB] FAIL redir_req: got %b want 1", req8); end
      checks++; if (addr8 !== 32'h40) begin errors++; $display("[TB] FAIL redir_addr: got %h want 40", addr8); end
      n = 0;
      while (valid8 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++; if (pc8 !== 32'h40)          begin errors++; $display("[TB] FAIL redir_pc: got %h want 40", pc8); end
      checks++; if (data8 !== 32'h19181B1A)  begin errors++; $display("[TB] FAIL redir_data: got %h want 19181b1a", data8); end
   endtask

   task automatic test_back_to_back();
      int n;
      ackEn32 = 1'b1;
      ready32 = 1'b1;
      doReset();
      n = 0;
      while (valid32 !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      for (int i = 0; i < 6; i++) begin
         checks++; if (valid32 !== 1'b1)       begin errors++; $display("[TB] FAIL stream_valid[%0d]: got %b want 1", i, valid32); end
         checks++; if (pc32 !== 32'(4*i))      begin errors++; $display("[TB] FAIL stream_pc[%0d]: got %h want %h", i, pc32, 32'(4*i)); end
         checks++; if (data32 !== expInstr(32'(4*i))) begin errors++; $display("[TB] FAIL stream_data[%0d]: got %h want %h", i, data32, expInstr(32'(4*i))); end
         @(negedge clk);
      end
   endtask

   task automatic test_wrap();
      redir32 = 1'b1;
      redirPc32 = 32'hFFFF_FFFE;
      @(negedge clk);
      redir32 = 1'b0;
      checks++; if (valid32 !== 1'b0)         begin errors++; $display("[TB] FAIL wrap_flush: got %b want 0", valid32); end
      checks++; if (addr32 !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_addr: got %h want fffffffc", addr32); end
      @(negedge clk);
      checks++; if (pc32 !== 32'hFFFF_FFFC)   begin errors++; $display("[TB] FAIL wrap_pc0: got %h want fffffffc", pc32); end
      checks++; if (data32 !== 32'hA5A4A7A6)  begin errors++; $display("[TB] FAIL wrap_data0: got %h want a5a4a7a6", data32); end
      @(negedge clk);
      checks++; if (pc32 !== 32'h0)           begin errors++; $display("[TB] FAIL wrap_pc1: got %h want 0", pc32); end
      checks++; if (data32 !== 32'h00100513)  begin errors++; $display("[TB] FAIL wrap_data1: got %h want 00100513", data32); end
      @(negedge clk);
      checks++; if (pc32 !== 32'h4)           begin errors++; $display("[TB] FAIL wrap_pc2: got %h want 4", pc32); end
   endtask

   task automatic test_reset_mid();
      int n;
      ready8 = 1'b0;
      ready32 = 1'b0;
      ackEn8 = 1'b1;
      ackEn32 = 1'b1;
      doReset();
      repeat (20) @(negedge clk);
      checks++; if (valid32 !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_valid32: got %b want 1", valid32); end
      checks++; if (req32 !== 1'b0)   begin errors++; $display("[TB] FAIL mid_pre_full32: got %b want 0", req32); end
      ready8 = 1'b1;
      @(negedge clk);
      ready8 = 1'b0;
      ackEn8 = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (req8 !== 1'b1)    begin errors++; $display("[TB] FAIL mid_pre_req8: got %b want 1", req8); end
      #2 rst = 1'b1;
      #1;
      checks++; if (req8 !== 1'b0)    begin errors++; $display("[TB] FAIL mid_req8: got %b want 0", req8); end
      checks++; if (busy8 !== 1'b0)   begin errors++; $display("[TB] FAIL mid_busy8: got %b want 0", busy8); end
      checks++; if (valid8 !== 1'b0)  begin errors++; $display("[TB] FAIL mid_valid8: got %b want 0", valid8); end
      checks++; if (valid32 !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid32: got %b want 0", valid32); end
      checks++; if (pc32 !== 32'h0)   begin errors++; $display("[TB] FAIL mid_pc32: got %h want 0", pc32); end
      @(negedge clk);
      ackEn8 = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (req8 !== 1'b1)    begin errors++; $display("[TB] FAIL restart_req8: got %b want 1", req8); end
      checks++; if (addr8 !== 32'h0)  begin errors++; $display("[TB] FAIL restart_addr8: got %h want 0", addr8); end
      n = 0;
      while (valid8 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++; if (pc8 !== 32'h0)          begin errors++; $display("[TB] FAIL restart_pc8: got %h want 0", pc8); end
      checks++; if (data8 !== 32'h00100513) begin errors++; $display("[TB] FAIL restart_data8: got %h want 00100513", data8); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      ackEn8 = 1'b0;
      ackEn32 = 1'b0;
      ready8 = 1'b0;
      ready32 = 1'b0;
      redir8 = 1'b0;
      redir32 = 1'b0;
      redirPc8 = 32'h0;
      redirPc32 = 32'h0;
      test_reset();
      test_bus8_fetch();
      test_full();
      test_redirect();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
